// File: rtl/hex_display_pkg.sv
// Purpose: shared constants, the display word payload and helpers for the
//          time-multiplexed hex display driver.
//   SEG_OFF       all segments dark (active low)
//   SEG_TABLE     16-entry hex -> {dp,g,f,e,d,c,b,a} active-low pattern, dp off
//   hex_word_t    display word: nibbles, dp mask, blank mask (sized for 8 digits)
//   f_lead_mask   leading-zero blank mask of a display value (digit 0 never set)
package hex_display_pkg;

    localparam int unsigned MAX_DIGITS = 8;
    localparam int unsigned SEL_W      = 3;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Element i holds the pattern for nibble value i.
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hA7, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    typedef struct packed {
        logic [4*MAX_DIGITS-1:0] value;
        logic [MAX_DIGITS-1:0]   dp;
        logic [MAX_DIGITS-1:0]   blank;
    } hex_word_t;

    // 1 marks digits above the highest non-zero nibble.
    function automatic logic [MAX_DIGITS-1:0] f_lead_mask(input logic [4*MAX_DIGITS-1:0] value);
        logic [MAX_DIGITS-1:0] mask;
        logic                  seen;
        mask = '0;
        seen = 1'b0;
        for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
            if (value[4*i +: 4] != 4'h0) seen = 1'b1;
            if (!seen) mask[i] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/m_hex_decoder.sv
// Purpose: hex nibble to active-low seven-segment pattern (dp bit left off).
//   i_nibble   in  4  hex digit
//   o_seg_n_c  out 8  {dp,g,f,e,d,c,b,a}, active low, combinational
module m_hex_decoder
    import hex_display_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [7:0] o_seg_n_c
);

    assign o_seg_n_c = SEG_TABLE[i_nibble];

endmodule

// File: rtl/m_hex_display_scan.sv
// Purpose: time-multiplexed N-digit hex driver for common-anode displays.
//   Holds a committed display word, scans one digit per slot, and commits a
//   pending word only at the frame wrap so a frame is never torn.
// Ports:
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_load             strobe capturing value/dp/blank as pending
//   i_value            4*N_DIGITS hex nibbles, digit 0 in [3:0]
//   i_dp_mask          per-digit decimal point
//   i_blank_mask       per-digit forced dark
//   i_enable           0 darkens outputs, scanning continues
//   o_seg_n            {dp,g,f,e,d,c,b,a}, active low, registered
//   o_an_n             one-hot-low anode select, registered
//   o_pending          load captured but not yet committed
//   o_frame_start      pulse in the cycle the scan wraps to digit 0
// Configuration: LEADING_ZERO_BLANK_EN darkens digits above the highest
//   non-zero nibble (digit 0 always shown, dp still honoured).
module m_hex_display_scan
    import hex_display_pkg::*;
#(
    parameter int unsigned N_DIGITS  = 4,
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_load,
    input  logic [4*N_DIGITS-1:0]   i_value,
    input  logic [N_DIGITS-1:0]     i_dp_mask,
    input  logic [N_DIGITS-1:0]     i_blank_mask,
    input  logic                    i_enable,
    output logic [7:0]              o_seg_n,
    output logic [N_DIGITS-1:0]     o_an_n,
    output logic                    o_pending,
    output logic                    o_frame_start
);

    localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [PRE_W-1:0]    r_pre;
    logic [IDX_W-1:0]    r_idx;
    hex_word_t           r_pend_word;
    hex_word_t           r_commit_word;
    logic                r_pending;
    logic                r_frame_start;
    logic [7:0]          r_seg_n;
    logic [N_DIGITS-1:0] r_an_n;

    logic                w_tc;
    logic                w_wrap;
    logic [3:0]          w_nibble;
    logic [7:0]          w_pat_n;
    logic                w_dp;
    logic                w_blank;
    logic                w_lead;
    logic                w_dark;
    logic [MAX_DIGITS-1:0] w_lead_mask;
    logic [7:0]          w_seg_d;
    logic [N_DIGITS-1:0] w_an_d;

    assign w_tc   = (r_pre == PRE_W'(SCAN_DIV - 1));
    assign w_wrap = w_tc && (r_idx == IDX_W'(N_DIGITS - 1));

    // Prescaler and digit index.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pre         <= '0;
            r_idx         <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_wrap;
            if (w_tc) begin
                r_pre <= '0;
                r_idx <= w_wrap ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_pre <= r_pre + PRE_W'(1);
            end
        end
    end

    // Pending/committed words: a load coinciding with the wrap stays pending,
    // the commit takes the older pending word.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pend_word   <= '0;
            r_commit_word <= '0;
            r_pending     <= 1'b0;
        end else begin
            if (w_wrap && r_pending) r_commit_word <= r_pend_word;
            if (i_load) begin
                r_pend_word <= '{value: 32'(i_value),
                                 dp:    8'(i_dp_mask),
                                 blank: 8'(i_blank_mask)};
                r_pending   <= 1'b1;
            end else if (w_wrap) begin
                r_pending   <= 1'b0;
            end
        end
    end

    // Single decoder fed by the currently scanned committed nibble.
    assign w_nibble = 4'(r_commit_word.value >> {r_idx, 2'b00});

    m_hex_decoder u_decoder (
        .i_nibble  (w_nibble),
        .o_seg_n_c (w_pat_n)
    );

    assign w_dp        = r_commit_word.dp[SEL_W'(r_idx)];
    assign w_blank     = r_commit_word.blank[SEL_W'(r_idx)];
    assign w_lead_mask = f_lead_mask(r_commit_word.value);

`ifdef LEADING_ZERO_BLANK_EN
    assign w_lead = w_lead_mask[SEL_W'(r_idx)];
`else
    assign w_lead = 1'b0 & w_lead_mask[SEL_W'(r_idx)];
`endif

    assign w_dark = (32'(r_pre) < BLANK_CYC) || !i_enable;

    // Next output values.
    always_comb begin
        w_seg_d = SEG_OFF;
        w_an_d  = '1;
        if (!w_dark) begin
            w_an_d = ~(N_DIGITS'(1) << r_idx);
            if (w_blank)     w_seg_d = SEG_OFF;
            else if (w_lead) w_seg_d = {~w_dp, 7'h7F};
            else             w_seg_d = {~w_dp, w_pat_n[6:0]};
        end
    end

    // Output register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_seg_n <= SEG_OFF;
            r_an_n  <= '1;
        end else begin
            r_seg_n <= w_seg_d;
            r_an_n  <= w_an_d;
        end
    end

    assign o_seg_n       = r_seg_n;
    assign o_an_n        = r_an_n;
    assign o_pending     = r_pending;
    assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_m_hex_display_scan.sv
// Purpose: randomized and directed self-checking bench for m_hex_display_scan
//   (N_DIGITS=4, SCAN_DIV=4, BLANK_CYC=1) against a cycle-count reference model.
module tb_m_hex_display_scan;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int BC = 1;
    localparam int FRAME = ND * SD;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic [3:0]  blank_mask;
    logic        enable;
    logic [7:0]  seg_n;
    logic [3:0]  an_n;
    logic        pending;
    logic        frame_start;

    m_hex_display_scan #(
        .N_DIGITS  (ND),
        .SCAN_DIV  (SD),
        .BLANK_CYC (BC)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_load        (load),
        .i_value       (value),
        .i_dp_mask     (dp_mask),
        .i_blank_mask  (blank_mask),
        .i_enable      (enable),
        .o_seg_n       (seg_n),
        .o_an_n        (an_n),
        .o_pending     (pending),
        .o_frame_start (frame_start)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: cycles since reset release plus the two words.
    int          m_tick;
    logic [15:0] m_cval, m_pval;
    logic [3:0]  m_cdp, m_cblank, m_pdp, m_pblank;
    logic        m_pend;

    logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hA7, 8'hA1, 8'h86, 8'h8E};
    logic [7:0] seen_seg [ND];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_seg(input int d);
        logic [3:0] nib;
        bit         lz;
        nib = m_cval[4*d +: 4];
        lz  = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if (d > 0 && (m_cval >> (4*d)) == 16'h0) lz = 1'b1;
`endif
        if (m_cblank[d]) return 8'hFF;
        if (lz)          return {~m_cdp[d], 7'h7F};
        return {~m_cdp[d], hex_tab[nib][6:0]};
    endfunction

    task automatic model_reset();
        m_tick = 0;
        m_cval = '0; m_cdp = '0; m_cblank = '0;
        m_pval = '0; m_pdp = '0; m_pblank = '0;
        m_pend = 1'b0;
    endtask

    task automatic clear_seen();
        for (int i = 0; i < ND; i++) seen_seg[i] = 8'h00;
    endtask

    // One clock: predict from model state and current inputs, then compare.
    task automatic cycle();
        int         pre;
        int         idx;
        bit         wrap;
        logic [7:0] e_seg;
        logic [3:0] e_an;
        pre  = m_tick % SD;
        idx  = (m_tick / SD) % ND;
        wrap = (m_tick % FRAME) == FRAME - 1;
        e_seg = 8'hFF;
        e_an  = 4'hF;
        if (pre >= BC && enable) begin
            e_an[idx] = 1'b0;
            e_seg     = ref_seg(idx);
        end
        if (wrap && m_pend) begin
            m_cval = m_pval; m_cdp = m_pdp; m_cblank = m_pblank;
            m_pend = 1'b0;
        end
        if (load) begin
            m_pval = value; m_pdp = dp_mask; m_pblank = blank_mask;
            m_pend = 1'b1;
        end
        m_tick++;
        @(posedge clk);
        @(negedge clk);
        check("seg_n", 32'(seg_n), 32'(e_seg));
        check("an_n", 32'(an_n), 32'(e_an));
        check("pending", 32'(pending), 32'(m_pend));
        check("frame_start", 32'(frame_start), 32'(wrap));
        if (an_n != 4'hF) seen_seg[idx] = seg_n;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
        load = 1'b1; value = v; dp_mask = dp; blank_mask = bl;
        cycle();
        load = 1'b0;
    endtask

    task automatic check_seen(input string tag, input logic [31:0] exp);
        for (int i = 0; i < ND; i++) check(tag, 32'(seen_seg[i]), 32'(exp[8*i +: 8]));
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; value = '0; dp_mask = '0; blank_mask = '0; enable = 1'b1;
        model_reset();
        clear_seen();
        @(negedge clk); @(negedge clk);
        check("rst_seg_n", 32'(seg_n), 32'hFF);
        check("rst_an_n", 32'(an_n), 32'hF);
        check("rst_pending", 32'(pending), 32'h0);
        check("rst_frame_start", 32'(frame_start), 32'h0);
        rst = 1'b0;

        // Idle scan shows zeros.
        run(2 * FRAME);
        check_seen("idle_digits", 32'hC0C0C0C0);

        // 12AF with dp on digit 0.
        clear_seen();
        do_load(16'h12AF, 4'b0001, 4'b0000);
        run(40);
        check_seen("load_12af", 32'hF9A4880E);

        // Two loads within one frame: only the last is ever shown.
        while (m_tick % FRAME != 2) cycle();
        do_load(16'h1111, 4'b0000, 4'b0000);
        run(3);
        do_load(16'h2222, 4'b0000, 4'b0000);
        clear_seen();
        run(40);
        check_seen("last_load_wins", 32'hA4A4A4A4);

        // Disabled for more than a frame.
        enable = 1'b0;
        run(FRAME + 3);
        enable = 1'b1;
        run(8);

        // Reset mid-slot.
        while (m_tick % SD != 2) cycle();
        do_load(16'h5555, 4'b0000, 4'b0000);
        #2 rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check("midrst_seg_n", 32'(seg_n), 32'hFF);
        check("midrst_an_n", 32'(an_n), 32'hF);
        check("midrst_pending", 32'(pending), 32'h0);
        model_reset();
        rst = 1'b0;
        clear_seen();
        run(FRAME + 2);
        check_seen("post_rst", 32'hC0C0C0C0);

        // Leading zero behaviour.
        do_load(16'h0050, 4'b0000, 4'b0000);
        clear_seen();
        run(40);
`ifdef LEADING_ZERO_BLANK_EN
        check_seen("value_0050", 32'hFFFF92C0);
`else
        check_seen("value_0050", 32'hC0C092C0);
`endif
        do_load(16'h0000, 4'b0000, 4'b0000);
        clear_seen();
        run(40);
`ifdef LEADING_ZERO_BLANK_EN
        check_seen("value_0000", 32'hFFFFFFC0);
`else
        check_seen("value_0000", 32'hC0C0C0C0);
`endif

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            enable = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 9) == 0) begin
                load       = 1'b1;
                value      = 16'($urandom);
                dp_mask    = 4'($urandom);
                blank_mask = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
                if ($urandom_range(0, 3) == 0) value = value & 16'h00FF;
            end else begin
                load = 1'b0;
            end
            cycle();
        end
        load = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
